// File: rtl/tcdm_synch_multi_ipa.sv
// N-port transfer-completion barrier: one SID FIFO per source port, one synch
// event released (and each enabled FIFO popped) once every enabled port holds a SID.
module tcdm_synch_multi_ipa #(
    parameter int NB_PORTS        = 2,
    parameter int TRANS_SID_WIDTH = 2,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NB_PORTS-1:0]                           push_req_i,
    input  logic [NB_PORTS-1:0][TRANS_SID_WIDTH-1:0]      push_sid_i,
    output logic [NB_PORTS-1:0]                           push_gnt_o,
    input  logic [NB_PORTS-1:0]                           port_en_i,
    input  logic                                          ovf_clr_i,
    output logic                                          synch_req_o,
    output logic [TRANS_SID_WIDTH-1:0]                    synch_sid_o,
    output logic                                          synch_err_o,
    output logic [NB_PORTS-1:0]                           ovf_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    typedef logic [TRANS_SID_WIDTH-1:0] sid_t;

    sid_t [NB_PORTS-1:0][FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [NB_PORTS-1:0][PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [NB_PORTS-1:0][PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [NB_PORTS-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [NB_PORTS-1:0]                 ovf_q, ovf_d;

    sid_t [NB_PORTS-1:0] head;
    logic [NB_PORTS-1:0] not_ready;
    logic [NB_PORTS-1:0] head_diff;
    logic [NB_PORTS-1:0] push_ok;
    logic [NB_PORTS-1:0] pop;
    logic                barrier_rel;
    logic                found;
    sid_t                ref_sid;

    // Barrier decision: reference SID comes from the lowest-index enabled port.
    always_comb begin
        push_gnt_o  = '0;
        head        = '0;
        not_ready   = '0;
        head_diff   = '0;
        found       = 1'b0;
        ref_sid     = '0;
        for (int i = 0; i < NB_PORTS; i++) begin
            push_gnt_o[i] = (cnt_q[i] != DEPTH_CNT);
            head[i]       = mem_q[i][rd_ptr_q[i]];
            not_ready[i]  = port_en_i[i] && (cnt_q[i] == '0);
            if (port_en_i[i] && !found) begin
                found = 1'b1;
                if (cnt_q[i] != '0) begin
                    ref_sid = head[i];
                end
            end
        end
        barrier_rel = (|port_en_i) && !(|not_ready);
        for (int i = 0; i < NB_PORTS; i++) begin
            head_diff[i] = port_en_i[i] && (head[i] != ref_sid);
        end
        synch_req_o = barrier_rel;
        synch_sid_o = ref_sid;
        synch_err_o = barrier_rel && (|head_diff);
        ovf_o       = ovf_q;
    end

    // FIFO bookkeeping; a push on a full FIFO is dropped even if that FIFO pops this cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        push_ok  = '0;
        pop      = '0;
        for (int i = 0; i < NB_PORTS; i++) begin
            push_ok[i] = push_req_i[i] && push_gnt_o[i];
            pop[i]     = barrier_rel && port_en_i[i];
            if (push_ok[i]) begin
                mem_d[i][wr_ptr_q[i]] = push_sid_i[i];
                wr_ptr_d[i] = (wr_ptr_q[i] == LAST_PTR) ? '0 : wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = (rd_ptr_q[i] == LAST_PTR) ? '0 : rd_ptr_q[i] + PTR_W'(1);
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
            ovf_d[i] = (push_req_i[i] && !push_gnt_o[i]) || (ovf_q[i] && !ovf_clr_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_tcdm_synch_multi_ipa.sv
// Directed, table-driven bench for the 4-port, depth-2 barrier; 2-port cases run with en=0011.
module tb_tcdm_synch_multi_ipa;

    logic            clk_i;
    logic            rst_ni;
    logic [3:0]      push_req_i;
    logic [3:0][1:0] push_sid_i;
    logic [3:0]      push_gnt_o;
    logic [3:0]      port_en_i;
    logic            ovf_clr_i;
    logic            synch_req_o;
    logic [1:0]      synch_sid_o;
    logic            synch_err_o;
    logic [3:0]      ovf_o;

    int checks = 0;
    int errors = 0;

    tcdm_synch_multi_ipa #(
        .NB_PORTS       (4),
        .TRANS_SID_WIDTH(2),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_req_i (push_req_i),
        .push_sid_i (push_sid_i),
        .push_gnt_o (push_gnt_o),
        .port_en_i  (port_en_i),
        .ovf_clr_i  (ovf_clr_i),
        .synch_req_o(synch_req_o),
        .synch_sid_o(synch_sid_o),
        .synch_err_o(synch_err_o),
        .ovf_o      (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] req;
        logic [7:0] sid;
        logic [3:0] en;
        logic       clr;
        logic [3:0] gnt;
        logic       sreq;
        logic [1:0] ssid;
        logic       serr;
        logic [3:0] ovf;
    } vec_t;

    vec_t vecs [32];

    // Drive one cycle's inputs at the falling edge; the next rising edge consumes them.
    task automatic applyStimulus(input logic [3:0] req, input logic [7:0] sid,
                                 input logic [3:0] en, input logic clr);
        @(negedge clk_i);
        push_req_i = req;
        push_sid_i = sid;
        port_en_i  = en;
        ovf_clr_i  = clr;
    endtask

    task automatic checkOne(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] gnt, input logic sreq,
                               input logic [1:0] ssid, input logic serr, input logic [3:0] ovf);
        #1;
        checkOne({tag, "/gnt"},  {4'b0, push_gnt_o},  {4'b0, gnt});
        checkOne({tag, "/req"},  {7'b0, synch_req_o}, {7'b0, sreq});
        checkOne({tag, "/sid"},  {6'b0, synch_sid_o}, {6'b0, ssid});
        checkOne({tag, "/err"},  {7'b0, synch_err_o}, {7'b0, serr});
        checkOne({tag, "/ovf"},  {4'b0, ovf_o},       {4'b0, ovf});
    endtask

    logic [1:0] t5_sid [6];

    initial begin
        //                 req      sid    en       clr   gnt      sreq  ssid  serr  ovf
        vecs[0]  = '{4'b0001, 8'h01, 4'b0011, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[1]  = '{4'b0000, 8'h00, 4'b0011, 1'b0, 4'b1111, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[2]  = '{4'b0000, 8'h00, 4'b0011, 1'b0, 4'b1111, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[3]  = '{4'b0010, 8'h04, 4'b0011, 1'b0, 4'b1111, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[4]  = '{4'b0000, 8'h00, 4'b0011, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0000};
        vecs[5]  = '{4'b0000, 8'h00, 4'b0011, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[6]  = '{4'b0011, 8'h0E, 4'b0011, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[7]  = '{4'b0000, 8'h00, 4'b0011, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b1, 4'b0000};
        vecs[8]  = '{4'b0000, 8'h00, 4'b0011, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[9]  = '{4'b0010, 8'h04, 4'b0001, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[10] = '{4'b0010, 8'h08, 4'b0001, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[11] = '{4'b0010, 8'h0C, 4'b0001, 1'b0, 4'b1101, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[12] = '{4'b0001, 8'h01, 4'b0001, 1'b0, 4'b1101, 1'b0, 2'd0, 1'b0, 4'b0010};
        vecs[13] = '{4'b0000, 8'h00, 4'b0001, 1'b0, 4'b1101, 1'b1, 2'd1, 1'b0, 4'b0010};
        vecs[14] = '{4'b0000, 8'h00, 4'b0001, 1'b1, 4'b1101, 1'b0, 2'd0, 1'b0, 4'b0010};
        vecs[15] = '{4'b0000, 8'h00, 4'b0001, 1'b0, 4'b1101, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[16] = '{4'b0000, 8'h00, 4'b0010, 1'b0, 4'b1101, 1'b1, 2'd1, 1'b0, 4'b0000};
        vecs[17] = '{4'b0000, 8'h00, 4'b0010, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000};
        vecs[18] = '{4'b0000, 8'h00, 4'b0010, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[19] = '{4'b1111, 8'h00, 4'b1111, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[20] = '{4'b1111, 8'h55, 4'b1111, 1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000};
        vecs[21] = '{4'b1111, 8'hAA, 4'b1111, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0000};
        vecs[22] = '{4'b1111, 8'hFF, 4'b1111, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000};
        vecs[23] = '{4'b0000, 8'h00, 4'b1111, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b0, 4'b0000};
        vecs[24] = '{4'b0000, 8'h00, 4'b1111, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[25] = '{4'b1000, 8'h40, 4'b0000, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[26] = '{4'b1000, 8'h80, 4'b0000, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[27] = '{4'b1000, 8'hC0, 4'b0000, 1'b1, 4'b0111, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[28] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 4'b0111, 1'b0, 2'd0, 1'b0, 4'b1000};
        vecs[29] = '{4'b0000, 8'h00, 4'b1000, 1'b1, 4'b0111, 1'b1, 2'd1, 1'b0, 4'b1000};
        vecs[30] = '{4'b0000, 8'h00, 4'b1000, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000};
        vecs[31] = '{4'b0000, 8'h00, 4'b1000, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};

        t5_sid[0] = 2'd0; t5_sid[1] = 2'd1; t5_sid[2] = 2'd3;
        t5_sid[3] = 2'd0; t5_sid[4] = 2'd1; t5_sid[5] = 2'd2;

        push_req_i = '0;
        push_sid_i = '0;
        port_en_i  = 4'b0011;
        ovf_clr_i  = 1'b0;
        rst_ni     = 1'b1;
        #2 rst_ni  = 1'b0;
        checkOutput("reset", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int k = 0; k < 32; k++) begin
            applyStimulus(vecs[k].req, vecs[k].sid, vecs[k].en, vecs[k].clr);
            checkOutput($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].sreq,
                        vecs[k].ssid, vecs[k].serr, vecs[k].ovf);
        end

        // Fill p0/p1 to depth with no port enabled, then push and release every cycle.
        applyStimulus(4'b0011, 8'h00, 4'b0000, 1'b0);
        checkOutput("t5_fill0", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000);
        applyStimulus(4'b0011, 8'h05, 4'b0000, 1'b0);
        checkOutput("t5_fill1", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            logic [1:0] s;
            s = 2'((k + 2) % 4);
            applyStimulus(4'b0011, {4'b0, s, s}, 4'b0011, 1'b0);
            checkOutput($sformatf("t5_run%0d", k), (k == 0) ? 4'b1100 : 4'b1111, 1'b1,
                        t5_sid[k], 1'b0, (k == 0) ? 4'b0000 : 4'b0011);
        end
        applyStimulus(4'b0000, 8'h00, 4'b0011, 1'b0);
        checkOutput("t5_tail", 4'b1111, 1'b1, 2'd3, 1'b0, 4'b0011);
        applyStimulus(4'b0000, 8'h00, 4'b0011, 1'b0);
        checkOutput("t5_empty", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0011);

        // Queue one SID in p0 and p1 with the barrier disabled, then reset mid-operation.
        applyStimulus(4'b0011, 8'h09, 4'b0000, 1'b0);
        checkOutput("t6_push", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0011);
        applyStimulus(4'b0000, 8'h00, 4'b0000, 1'b0);
        checkOutput("t6_held", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0011);
        @(negedge clk_i);
        port_en_i = 4'b0011;
        rst_ni    = 1'b0;
        checkOutput("t6_rst", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 8'h00, 4'b0011, 1'b0);
            checkOutput($sformatf("t6_idle%0d", k), 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000);
        end
        applyStimulus(4'b0001, 8'h03, 4'b0011, 1'b0);
        checkOutput("t6_p0", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000);
        applyStimulus(4'b0010, 8'h0C, 4'b0011, 1'b0);
        checkOutput("t6_p1", 4'b1111, 1'b0, 2'd3, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 8'h00, 4'b0011, 1'b0);
        checkOutput("t6_rel", 4'b1111, 1'b1, 2'd3, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 8'h00, 4'b0011, 1'b0);
        checkOutput("t6_done", 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
